serial_addsub_seq: RTL
======================

# serial_addsub_seq

Sequencer placed in front of and behind the bit-serial adder (`full_adder`), upstream and downstream at once. It accepts add/subtract requests on a valid/ready interface and forms the adder operands, with two's-complement conversion for subtract. It pulses the adder's `load`, waits out the adder's fixed serial latency, then captures sum and flags. The result goes out on a second valid/ready interface with zero and borrow-corrected carry flags.

## Interface
- `ADDER_LENGTH`, default 8: operand/result width; must match the adder instance.
- `CAPTURE_DELAY`, default `ADDER_LENGTH+1`: cycles from the adder load cycle to the cycle where `add_s`/`add_cf`/`add_of` are final.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; equals (state==IDLE).
- `req_a`, `req_b` in `ADDER_LENGTH`: operands.
- `req_sub` in 1: 0 = a+b+cin; 1 = a−b−borrow.
- `req_cin` in 1: carry-in for add; borrow-in for sub.
- `add_load` out 1: one-cycle load pulse to the adder.
- `add_a`, `add_b` out `ADDER_LENGTH`: registered adder operands.
- `add_cin` out 1: registered adder carry-in.
- `add_s` in `ADDER_LENGTH`: adder sum.
- `add_cf`, `add_of` in 1: adder flags.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_result` out `ADDER_LENGTH`: captured sum.
- `rsp_cf`, `rsp_of`, `rsp_zero`, `rsp_sub` out 1: carry/borrow, overflow, result==0, and operation echo.
- `busy` out 1: state != IDLE.

## Operation
- FSM: IDLE → LOAD → RUN → DONE → IDLE.
- IDLE: on `req_valid`, register operands:
  - `add_a = req_a`.
  - `add_b = req_sub ? ~req_b : req_b`.
  - `add_cin = req_sub ? ~req_cin : req_cin`.
  - Latch `req_sub`, then go to LOAD.
- LOAD, exactly one cycle: `add_load=1`, counter cleared, then RUN.
- RUN: counter increments each cycle. When counter == `CAPTURE_DELAY-1`, capture:
  - `rsp_result = add_s`.
  - `rsp_of = add_of`.
  - `rsp_cf = add_cf ^ sub`, so subtract reports borrow.
  - `rsp_zero = (add_s == 0)`.
  - Then go to DONE.
- DONE: `rsp_valid=1`. All `rsp_*` outputs stay stable until `rsp_ready` is high at a rising edge, then go to IDLE.
- `add_a`/`add_b`/`add_cin` stay stable from capture until the next accepted request.
- `add_load` is 0 in every state except LOAD.
- Arithmetic is modulo 2^`ADDER_LENGTH`. The counter is `$clog2(CAPTURE_DELAY)+1` bits and never wraps within an operation.
- No request is accepted in LOAD/RUN/DONE. `req_valid` held there is ignored and accepted only once back in IDLE.
- Reset values (asynchronous on `rst_n` low), in any state including mid-RUN:
  - State IDLE, so `req_ready=1` and `busy=0`.
  - `add_load=0`, `rsp_valid=0`.
  - All data and flag outputs 0.

## Timing
- Request handshake at edge E0 → `add_load` high during cycle E0+1.
- Adder result sampled at the end of cycle E0+1+`CAPTURE_DELAY`.
- `rsp_valid` rises in cycle E0+`CAPTURE_DELAY`+2; this is 11 cycles at defaults.
- Response handshake at edge R → `req_ready` high in cycle R+1, so the next accept is at the earliest at edge R+1.
- Minimum issue interval: `CAPTURE_DELAY`+3 cycles.
- All outputs are registered or decoded from the state only. There is no combinational path from `req_*` or `rsp_ready` to outputs.

## Structure
- Package `serial_alu_pkg` holds:
  - State enum (IDLE, LOAD, RUN, DONE).
  - Default `ADDER_LENGTH`.
  - The operand-conditioning function (invert b/cin on sub).
- No sub-module. The parent instantiates `serial_addsub_seq` and `full_adder` side by side and connects `add_*`.

## Test plan
Defaults; bench uses a behavioural adder model with exact `CAPTURE_DELAY` latency.
1. Add 0x35+0x4A, cin 0 → `add_b`=0x4A, `add_cin`=0, result 0x7F, cf 0, of 0, zero 0; `rsp_valid` 11 cycles after accept.
2. Sub 0x10−0x20, borrow 0 → `add_b`=0xDF, `add_cin`=1, result 0xF0, `rsp_cf`=1 (borrow), of 0, `rsp_sub`=1.
3. Add 0x7F+0x01 → 0x80, of 1, cf 0; then add 0xFF+0x01 → 0x00, zero 1, cf 1.
4. Hold `rsp_ready` low 5 cycles in DONE while `req_valid` stays high → `rsp_*` stable, `req_ready`=0, no second accept. Accept occurs exactly one edge after the response handshake.
5. Drop `rst_n` at RUN counter=4 → immediately `add_load`=0, `rsp_valid`=0, `busy`=0, `req_ready`=1. Next request (0x01+0x02) completes with result 0x03 and normal latency.
6. Back-to-back requests with `rsp_ready` tied high → one `add_load` pulse per operation, issue interval exactly 12 cycles, all results correct.

Source files
------------

// File: rtl/serial_addsub_seq_pkg.sv
// ============================================================================
//  Module  : serial_alu_pkg (package)
//  Purpose : Shared types and helpers for the serial add/subtract sequencer.
//            Holds the sequencer state encoding, the default operand width
//            and the operand-conditioning helper used to turn a subtract
//            into an add of the one's complement.
//  Contents: DEFAULT_ADDER_LENGTH - default operand/result width
//            state_t              - IDLE / LOAD / RUN / DONE
//            condition_bit()      - invert one operand bit when subtracting
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_alu_pkg;

  localparam int DEFAULT_ADDER_LENGTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // a - b - borrow == a + ~b + ~borrow (mod 2^N): on subtract, both the
  // b operand bits and the carry-in are inverted before reaching the adder.
  function automatic logic condition_bit(input logic sub, input logic x);
    return x ^ sub;
  endfunction

endpackage : serial_alu_pkg

`default_nettype wire

// File: rtl/serial_addsub_seq_if.sv
// ============================================================================
//  Module  : serial_addsub_seq_if (interface)
//  Purpose : Bundles the request channel, the adder-side operand/result
//            signals and the response channel of the sequencer.
//  Ports   : req_*  - request valid/ready channel (a, b, sub, cin)
//            add_*  - load pulse and operands to the adder, sum/flags back
//            rsp_*  - response valid/ready channel (result, cf, of, zero, sub)
//            busy   - sequencer not idle
//  Modports: slave  - the sequencer side
//            master - the environment side (requester, adder, consumer)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_addsub_seq_if
  import serial_alu_pkg::*;
#(
  parameter int ADDER_LENGTH = DEFAULT_ADDER_LENGTH
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic [ADDER_LENGTH-1:0] req_a;
  logic [ADDER_LENGTH-1:0] req_b;
  logic                    req_sub;
  logic                    req_cin;

  logic                    add_load;
  logic [ADDER_LENGTH-1:0] add_a;
  logic [ADDER_LENGTH-1:0] add_b;
  logic                    add_cin;
  logic [ADDER_LENGTH-1:0] add_s;
  logic                    add_cf;
  logic                    add_of;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ADDER_LENGTH-1:0] rsp_result;
  logic                    rsp_cf;
  logic                    rsp_of;
  logic                    rsp_zero;
  logic                    rsp_sub;

  logic                    busy;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_cin,
    output req_ready,
    output add_load, add_a, add_b, add_cin,
    input  add_s, add_cf, add_of,
    output rsp_valid, rsp_result, rsp_cf, rsp_of, rsp_zero, rsp_sub,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, req_cin,
    input  req_ready,
    input  add_load, add_a, add_b, add_cin,
    output add_s, add_cf, add_of,
    input  rsp_valid, rsp_result, rsp_cf, rsp_of, rsp_zero, rsp_sub,
    output rsp_ready,
    input  busy
  );

endinterface : serial_addsub_seq_if

`default_nettype wire

// File: rtl/serial_addsub_seq.sv
// ============================================================================
//  Module  : serial_addsub_seq
//  Purpose : Sequencer wrapped around a bit-serial adder. Accepts add/sub
//            requests, registers conditioned operands, pulses the adder's
//            load, waits out the adder latency, captures sum and flags and
//            presents them on a valid/ready response channel.
//  Ports   : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - serial_addsub_seq_if.slave (req_*, add_*, rsp_*, busy)
//  Params  : ADDER_LENGTH  - operand/result width (must match the adder)
//            CAPTURE_DELAY - cycles from the load cycle to final adder outputs
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_seq
  import serial_alu_pkg::*;
#(
  parameter int ADDER_LENGTH  = DEFAULT_ADDER_LENGTH,
  parameter int CAPTURE_DELAY = ADDER_LENGTH + 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_addsub_seq_if.slave bus
);

  // One spare bit so the counter can never wrap before reaching its target.
  localparam int                 c_CNT_W    = $clog2(CAPTURE_DELAY) + 1;
  localparam logic [c_CNT_W-1:0] c_CAP_LAST = c_CNT_W'(CAPTURE_DELAY - 1);

  state_t                  r_state;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [ADDER_LENGTH-1:0] r_add_a;
  logic [ADDER_LENGTH-1:0] r_add_b;
  logic                    r_add_cin;
  logic                    r_sub;
  logic [ADDER_LENGTH-1:0] r_rsp_result;
  logic                    r_rsp_cf;
  logic                    r_rsp_of;
  logic                    r_rsp_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_add_cin    <= 1'b0;
      r_sub        <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cf     <= 1'b0;
      r_rsp_of     <= 1'b0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_add_a <= bus.req_a;
            for (int i = 0; i < ADDER_LENGTH; i++) begin
              r_add_b[i] <= condition_bit(bus.req_sub, bus.req_b[i]);
            end
            r_add_cin <= condition_bit(bus.req_sub, bus.req_cin);
            r_sub     <= bus.req_sub;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (r_cnt == c_CAP_LAST) begin
            r_rsp_result <= bus.add_s;
            r_rsp_of     <= bus.add_of;
            // Carry-out of a + ~b + ~borrow is the inverse of the borrow.
            r_rsp_cf     <= bus.add_cf ^ r_sub;
            r_rsp_zero   <= (bus.add_s == '0);
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake/status outputs are decoded from the state register only.
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.add_load   = (r_state == ST_LOAD);
  assign bus.rsp_valid  = (r_state == ST_DONE);

  assign bus.add_a      = r_add_a;
  assign bus.add_b      = r_add_b;
  assign bus.add_cin    = r_add_cin;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_cf     = r_rsp_cf;
  assign bus.rsp_of     = r_rsp_of;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_sub    = r_sub;

endmodule : serial_addsub_seq

`default_nettype wire
